// File: rtl/tiny16_pkg.sv
// tiny16_pkg: shared register indices, bank defaults and stack-op encoding for the tiny16 core family.
package tiny16_pkg;
    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 16;
    localparam int REG_ZERO     = 0;
    localparam int REG_PC       = 1;
    localparam int REG_SP       = 2;
    localparam int REG_BP       = 3;
    localparam logic [15:0] SP_INIT_DEF  = 16'h00FF;
    localparam logic [15:0] SP_LIMIT_DEF = 16'h0080;
    typedef enum logic [1:0] {
        SP_HOLD = 2'b00,
        SP_POP  = 2'b01,
        SP_PUSH = 2'b10,
        SP_BOTH = 2'b11
    } sp_op_e;
endpackage

// File: rtl/reg_bank_sp_ctl.sv
// reg_bank_sp_ctl: next stack-pointer value and sticky-flag set pulses.
// Push/pop override a same-cycle write; bounds are checked only on push/pop.
module reg_bank_sp_ctl import tiny16_pkg::*; #(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEF),
    parameter logic [DATA_W-1:0] SP_LIMIT = DATA_W'(SP_LIMIT_DEF)
) (
    input  logic [DATA_W-1:0] sp_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              wr_req_i,
    input  logic [DATA_W-1:0] wr_val_i,
    output logic [DATA_W-1:0] sp_d_o,
    output logic              ovf_set_o,
    output logic              unf_set_o
);
    sp_op_e op;
    logic   can_push;
    logic   can_pop;
    always_comb begin
        op        = sp_op_e'({push_i, pop_i});
        can_push  = sp_i > SP_LIMIT;
        can_pop   = sp_i < SP_INIT;
        sp_d_o    = op == SP_PUSH ? (can_push ? sp_i - DATA_W'(1) : sp_i) :
                    op == SP_POP  ? (can_pop  ? sp_i + DATA_W'(1) : sp_i) :
                    op == SP_BOTH ? sp_i :
                    wr_req_i      ? wr_val_i : sp_i;
        ovf_set_o = op == SP_PUSH && !can_push;
        unf_set_o = op == SP_POP  && !can_pop;
    end
endmodule

// File: rtl/reg_bank.sv
// reg_bank: tiny16 register bank, byte-lane write port, two read ports, PC/SP auto-update.
// Define REG_BANK_BYPASS_EN to make reads return the post-edge value (write-through).
module reg_bank import tiny16_pkg::*; #(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                NUM_REGS = NUM_REGS_DEF,
    localparam int               SEL_W    = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEF),
    parameter logic [DATA_W-1:0] SP_LIMIT = DATA_W'(SP_LIMIT_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    src_sel,
    input  logic [SEL_W-1:0]    dst_sel,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                wr_imm8,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                pc_inc,
    input  logic                sp_push,
    input  logic                sp_pop,
    input  logic                flag_clr,
    output logic [DATA_W-1:0]   src,
    output logic [DATA_W-1:0]   dst,
    output logic                stack_ovf,
    output logic                stack_unf
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] gpr_d [NUM_REGS];
    logic [DATA_W-1:0] wr_val;
    logic [DATA_W-1:0] sp_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              ovf_set, unf_set;

    reg_bank_sp_ctl #(
        .DATA_W  (DATA_W),
        .SP_INIT (SP_INIT),
        .SP_LIMIT(SP_LIMIT)
    ) u_sp_ctl (
        .sp_i     (gpr_q[REG_SP]),
        .push_i   (sp_push),
        .pop_i    (sp_pop),
        .wr_req_i (wr_en && dst_sel == SEL_W'(REG_SP)),
        .wr_val_i (wr_val),
        .sp_d_o   (sp_d),
        .ovf_set_o(ovf_set),
        .unf_set_o(unf_set)
    );

    // Disabled lanes keep the destination's current byte, so wr_val is the full merged word.
    always_comb begin
        for (int l = 0; l < NB; l++)
            wr_val[8*l +: 8] = wr_be[l] ? (wr_imm8 ? wr_data[7:0] : wr_data[8*l +: 8])
                                        : gpr_q[dst_sel][8*l +: 8];
        for (int i = 0; i < NUM_REGS; i++)
            gpr_d[i] = (wr_en && dst_sel == SEL_W'(i)) ? wr_val : gpr_q[i];
        gpr_d[REG_ZERO] = '0;
        gpr_d[REG_PC]   = pc_inc ? gpr_q[REG_PC] + DATA_W'(1) : gpr_d[REG_PC];
        gpr_d[REG_SP]   = sp_d;
        ovf_d           = ovf_set | (ovf_q & ~flag_clr);
        unf_d           = unf_set | (unf_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                gpr_q[i] <= (i == REG_SP) ? SP_INIT : '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            gpr_q <= gpr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    assign src = gpr_d[src_sel];
    assign dst = gpr_d[dst_sel];
`else
    assign src = gpr_q[src_sel];
    assign dst = gpr_q[dst_sel];
`endif
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
endmodule
